// File: rtl/bit_channel_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the shared consumer.
interface bit_channel_arbiter_if #(
  parameter int unsigned WIDTH = 1
);
  logic             I0_valid;
  logic [WIDTH-1:0] I0_data;
  logic             I0_last;
  logic             I0_ready;
  logic             I1_valid;
  logic [WIDTH-1:0] I1_data;
  logic             I1_last;
  logic             I1_ready;
  logic             O_valid;
  logic [WIDTH-1:0] O_data;
  logic             O_last;
  logic             O_src;
  logic             O_ready;

  modport slave (
    input  I0_valid, I0_data, I0_last, I1_valid, I1_data, I1_last, O_ready,
    output I0_ready, I1_ready, O_valid, O_data, O_last, O_src
  );

  modport master (
    output I0_valid, I0_data, I0_last, I1_valid, I1_data, I1_last, O_ready,
    input  I0_ready, I1_ready, O_valid, O_data, O_last, O_src
  );
endinterface

// File: rtl/bit_channel_arbiter.sv
// Packet-locking two-way round-robin arbiter feeding a one-entry registered output channel.
module bit_channel_arbiter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  bit_channel_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t           state, state_n;
  logic             prio, prio_n;
  logic             o_valid_q, o_last_q, o_src_q;
  logic [WIDTH-1:0] o_data_q;

  logic [1:0]       in_valid, in_last, in_ready;
  logic [WIDTH-1:0] in_data [2];
  logic             can_load, sel, gnt, accept;

  assign in_valid   = {bus.I1_valid, bus.I0_valid};
  assign in_last    = {bus.I1_last, bus.I0_last};
  assign in_data[0] = bus.I0_data;
  assign in_data[1] = bus.I1_data;

  always_comb begin
    can_load = !o_valid_q || bus.O_ready;
    sel      = 1'b0;
    gnt      = 1'b0;
    in_ready = '0;
    accept   = 1'b0;
    state_n  = state;
    prio_n   = prio;

    case (state)
      IDLE: begin
        if (in_valid[prio]) begin
          sel = prio;
          gnt = 1'b1;
        end else if (in_valid[!prio]) begin
          sel = !prio;
          gnt = 1'b1;
        end
      end
      LOCK0: begin
        sel = 1'b0;
        gnt = 1'b1;
      end
      LOCK1: begin
        sel = 1'b1;
        gnt = 1'b1;
      end
      default: begin
        sel = 1'b0;
        gnt = 1'b0;
      end
    endcase

    // A locked requester sees ready whenever the register can load, even with valid low.
    in_ready[sel] = gnt && can_load && !RESET;
    accept        = in_ready[sel] && in_valid[sel];

    if (accept) begin
      if (in_last[sel]) begin
        state_n = IDLE;
        prio_n  = !sel;
      end else begin
        state_n = sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= 1'b0;
    end else if (accept) begin
      o_valid_q <= 1'b1;
      o_data_q  <= in_data[sel];
      o_last_q  <= in_last[sel];
      o_src_q   <= sel;
    end else if (bus.O_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign bus.I0_ready = in_ready[0];
  assign bus.I1_ready = in_ready[1];
  assign bus.O_valid  = o_valid_q;
  assign bus.O_data   = o_data_q;
  assign bus.O_last   = o_last_q;
  assign bus.O_src    = o_src_q;
endmodule

// File: tb/tb_bit_channel_arbiter.sv
// Vector table for readies/O_valid plus a scoreboard of accepted beats checked on consumption.
`timescale 1ns/1ps
module tb_bit_channel_arbiter;
  localparam int unsigned W = 4;

  typedef struct packed {
    bit         rst;
    bit         v0;
    bit [W-1:0] d0;
    bit         l0;
    bit         v1;
    bit [W-1:0] d1;
    bit         l1;
    bit         ordy;
    bit         er0;
    bit         er1;
    bit         eov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         src;
  } beat_t;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;
  vec_t  tbl[$];
  beat_t sb[$];

  bit_channel_arbiter_if #(.WIDTH(W)) bus ();

  bit_channel_arbiter #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rst, bit v0, bit [W-1:0] d0, bit l0, bit v1, bit [W-1:0] d1,
                              bit l1, bit ordy, bit er0, bit er1, bit eov);
    vec_t v;
    v = '{rst, v0, d0, l0, v1, d1, l1, ordy, er0, er1, eov};
    return v;
  endfunction

  task automatic check_cleared();
    check("clr_valid", 32'(bus.O_valid), 32'd0);
    check("clr_data", 32'(bus.O_data), 32'd0);
    check("clr_last", 32'(bus.O_last), 32'd0);
    check("clr_src", 32'(bus.O_src), 32'd0);
  endtask

  task automatic step(input vec_t v);
    beat_t b;
    RESET        = v.rst;
    bus.I0_valid = v.v0;
    bus.I0_data  = v.d0;
    bus.I0_last  = v.l0;
    bus.I1_valid = v.v1;
    bus.I1_data  = v.d1;
    bus.I1_last  = v.l1;
    bus.O_ready  = v.ordy;
    #1;
    check("i0_ready", 32'(bus.I0_ready), 32'(v.er0));
    check("i1_ready", 32'(bus.I1_ready), 32'(v.er1));
    check("o_valid", 32'(bus.O_valid), 32'(v.eov));
    if (!v.rst) begin
      if (bus.O_valid && bus.O_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = sb.pop_front();
          check("o_data", 32'(bus.O_data), 32'(b.data));
          check("o_last", 32'(bus.O_last), 32'(b.last));
          check("o_src", 32'(bus.O_src), 32'(b.src));
        end
      end
      if (v.v0 && v.er0) sb.push_back('{v.d0, v.l0, 1'b0});
      if (v.v1 && v.er1) sb.push_back('{v.d1, v.l1, 1'b1});
    end
    @(posedge CLK);
    #1;
    if (v.rst) begin
      sb.delete();
      check_cleared();
    end
  endtask

  initial begin
    // rst v0 d0 l0 v1 d1 l1 ordy | er0 er1 eov
    tbl.push_back(mk(0, 1, 4'h1, 1, 0, 4'h0, 0, 1, 1, 0, 0)); // single beat from I0
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h2, 1, 1, 4'h3, 1, 1, 0, 1, 0)); // prio now favours I1
    tbl.push_back(mk(0, 1, 4'h4, 1, 1, 4'h5, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'h6, 1, 1, 4'h7, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 4'h8, 1, 1, 4'h9, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'hA, 1, 1, 0, 1, 0)); // restore prio=0
    tbl.push_back(mk(0, 1, 4'h1, 0, 1, 4'hB, 1, 1, 1, 0, 1)); // I0 3-beat packet, I1 waiting
    tbl.push_back(mk(0, 1, 4'h2, 0, 1, 4'hB, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'h3, 1, 1, 4'hB, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'hB, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h5, 1, 0, 4'h0, 0, 0, 1, 0, 0)); // backpressure
    tbl.push_back(mk(0, 1, 4'h6, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h6, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h6, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h6, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h6, 1, 0, 4'h0, 0, 1, 1, 0, 1)); // consume and reload together
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h7, 0, 0, 4'hF, 1, 1, 1, 0, 0)); // I0 lock, I1 data toggles
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'hE, 1, 1, 1, 0, 0)); // lock survives valid drop
    tbl.push_back(mk(0, 1, 4'h9, 1, 1, 4'hD, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'hD, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'h1, 0, 1, 0, 1, 0)); // I1 packet cut by reset
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 4'h2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 4'h0, 0, 1, 4'h3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h4, 1, 1, 4'h5, 1, 1, 1, 0, 0)); // prio back to 0
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));

    RESET        = 1'b1;
    bus.I0_valid = 1'b0;
    bus.I0_data  = '0;
    bus.I0_last  = 1'b0;
    bus.I1_valid = 1'b0;
    bus.I1_data  = '0;
    bus.I1_last  = 1'b0;
    bus.O_ready  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_i0_ready", 32'(bus.I0_ready), 32'd0);
    check("rst_i1_ready", 32'(bus.I1_ready), 32'd0);
    check_cleared();

    foreach (tbl[i]) step(tbl[i]);

    // Back-to-back single-beat packets from both sides: strict alternation starting at I1.
    for (int i = 0; i < 8; i++) begin
      bit [W-1:0] a, c;
      a = W'($urandom_range(0, 15));
      c = W'($urandom_range(0, 15));
      step(mk(0, 1, a, 1, 1, c, 1, 1, (i % 2) == 1, (i % 2) == 0, i != 0));
    end
    step(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 1));
    step(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 0));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
